// File: rtl/am2909_next_addr_ctrl.sv
// Next-address controller for a bank of Am2909 sequencer slices: opcode decode, loop counter, stack depth.
// Optional sticky stack-error flag enabled by defining AM2909_CTRL_STACK_ERR_EN.
module am2909_next_addr_ctrl #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             CP,
    input  logic             RST,
    input  logic [3:0]       I,
    input  logic             CC_N,
    input  logic             CCEN_N,
    input  logic [WIDTH-1:0] D,
    output logic [1:0]       S,
    output logic             FE,
    output logic             PUP,
    output logic             RE,
    output logic             ZERO,
    output logic             PL_N,
    output logic             MAP_N,
    output logic             VECT_N,
    output logic             FULL_N,
    output logic             CNT_Z,
    output logic             ERR
);

    localparam int DW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    localparam logic [3:0] OP_JZ   = 4'd0;
    localparam logic [3:0] OP_CJS  = 4'd1;
    localparam logic [3:0] OP_JMAP = 4'd2;
    localparam logic [3:0] OP_CJP  = 4'd3;
    localparam logic [3:0] OP_PUSH = 4'd4;
    localparam logic [3:0] OP_JSRP = 4'd5;
    localparam logic [3:0] OP_CJV  = 4'd6;
    localparam logic [3:0] OP_JRP  = 4'd7;
    localparam logic [3:0] OP_RFCT = 4'd8;
    localparam logic [3:0] OP_RPCT = 4'd9;
    localparam logic [3:0] OP_CRTN = 4'd10;
    localparam logic [3:0] OP_CJPP = 4'd11;
    localparam logic [3:0] OP_LDCT = 4'd12;
    localparam logic [3:0] OP_LOOP = 4'd13;
    localparam logic [3:0] OP_CONT = 4'd14;
    localparam logic [3:0] OP_TWB  = 4'd15;

    localparam logic [1:0] SRC_UPC = 2'b00;
    localparam logic [1:0] SRC_AR  = 2'b01;
    localparam logic [1:0] SRC_STK = 2'b10;
    localparam logic [1:0] SRC_D   = 2'b11;

    logic [WIDTH-1:0] r_cnt;
    logic [DW-1:0]    r_depth;

    logic             w_pass;
    logic             w_cnt_nz;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_dec;
    logic             w_clr;
    logic [1:0]       w_s;
    logic             w_re;
    logic             w_zero;
    logic             w_pl_n;
    logic             w_map_n;
    logic             w_vect_n;

    // The Am2909 file keeps accepting pushes/pops; only the tracked depth saturates.
    function automatic logic [DW-1:0] f_depth_push(input logic [DW-1:0] d);
        return (d == DEPTH_MAX) ? DEPTH_MAX : d + DW'(1);
    endfunction

    function automatic logic [DW-1:0] f_depth_pop(input logic [DW-1:0] d);
        return (d == '0) ? '0 : d - DW'(1);
    endfunction

    assign w_pass   = CCEN_N | ~CC_N;
    assign w_cnt_nz = (r_cnt != '0);
    assign w_full   = (r_depth == DEPTH_MAX);
    assign w_empty  = (r_depth == '0);

    always_comb begin
        w_s      = SRC_UPC;
        w_re     = 1'b1;
        w_zero   = 1'b1;
        w_pl_n   = 1'b0;
        w_map_n  = 1'b1;
        w_vect_n = 1'b1;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_load   = 1'b0;
        w_dec    = 1'b0;
        w_clr    = 1'b0;
        case (I)
            OP_JZ: begin
                w_zero = 1'b0;
                w_clr  = 1'b1;
            end
            OP_CJS: begin
                if (w_pass) begin
                    w_s    = SRC_D;
                    w_push = 1'b1;
                end
            end
            OP_JMAP: begin
                w_s     = SRC_D;
                w_map_n = 1'b0;
                w_pl_n  = 1'b1;
            end
            OP_CJP: begin
                if (w_pass) w_s = SRC_D;
            end
            OP_PUSH: begin
                w_push = 1'b1;
                if (w_pass) begin
                    w_load = 1'b1;
                    w_re   = 1'b0;
                end
            end
            OP_JSRP: begin
                w_s    = w_pass ? SRC_D : SRC_AR;
                w_push = 1'b1;
            end
            OP_CJV: begin
                w_vect_n = 1'b0;
                w_pl_n   = 1'b1;
                if (w_pass) w_s = SRC_D;
            end
            OP_JRP: begin
                w_s = w_pass ? SRC_D : SRC_AR;
            end
            OP_RFCT: begin
                if (w_cnt_nz) begin
                    w_s   = SRC_STK;
                    w_dec = 1'b1;
                end else begin
                    w_pop = 1'b1;
                end
            end
            OP_RPCT: begin
                if (w_cnt_nz) begin
                    w_s   = SRC_D;
                    w_dec = 1'b1;
                end
            end
            OP_CRTN: begin
                if (w_pass) begin
                    w_s   = SRC_STK;
                    w_pop = 1'b1;
                end
            end
            OP_CJPP: begin
                if (w_pass) begin
                    w_s   = SRC_D;
                    w_pop = 1'b1;
                end
            end
            OP_LDCT: begin
                w_load = 1'b1;
                w_re   = 1'b0;
            end
            OP_LOOP: begin
                if (w_pass) w_pop = 1'b1;
                else        w_s   = SRC_STK;
            end
            OP_CONT: begin
            end
            OP_TWB: begin
                if (w_pass) begin
                    w_pop = 1'b1;
                end else if (w_cnt_nz) begin
                    w_s   = SRC_STK;
                    w_dec = 1'b1;
                end else begin
                    w_s   = SRC_D;
                    w_pop = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Reset overrides the decoded pins so the slices see a clean Y=0 fetch.
    assign S      = RST ? SRC_UPC : w_s;
    assign FE     = RST ? 1'b1 : ~(w_push | w_pop);
    assign PUP    = RST ? 1'b0 : w_push;
    assign RE     = RST ? 1'b1 : w_re;
    assign ZERO   = RST ? 1'b0 : w_zero;
    assign PL_N   = RST ? 1'b0 : w_pl_n;
    assign MAP_N  = RST ? 1'b1 : w_map_n;
    assign VECT_N = RST ? 1'b1 : w_vect_n;

    assign FULL_N = ~w_full;
    assign CNT_Z  = ~w_cnt_nz;

    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= D;
        end else if (w_dec) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            r_depth <= '0;
        end else if (w_clr) begin
            r_depth <= '0;
        end else if (w_push) begin
            r_depth <= f_depth_push(r_depth);
        end else if (w_pop) begin
            r_depth <= f_depth_pop(r_depth);
        end
    end

`ifdef AM2909_CTRL_STACK_ERR_EN
    logic r_err;

    // Sticky: only reset clears it, JZ resets depth but leaves the flag.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if ((w_push && w_full) || (w_pop && w_empty)) begin
            r_err <= 1'b1;
        end
    end

    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_am2909_next_addr_ctrl.sv
// Bench for am2909_next_addr_ctrl: directed and random opcodes against an integer reference model.
// Honours AM2909_CTRL_STACK_ERR_EN for the expected ERR behaviour.
module tb_am2909_next_addr_ctrl;

    localparam int WIDTH = 12;
    localparam int DEPTH = 4;

    logic             CP;
    logic             RST;
    logic [3:0]       I;
    logic             CC_N;
    logic             CCEN_N;
    logic [WIDTH-1:0] D;
    logic [1:0]       S;
    logic             FE, PUP, RE, ZERO, PL_N, MAP_N, VECT_N, FULL_N, CNT_Z, ERR;

    int vectors;
    int miscompares;

    // Reference state
    int m_cnt;
    int m_depth;
    bit m_err;

    am2909_next_addr_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CP(CP), .RST(RST), .I(I), .CC_N(CC_N), .CCEN_N(CCEN_N), .D(D),
        .S(S), .FE(FE), .PUP(PUP), .RE(RE), .ZERO(ZERO),
        .PL_N(PL_N), .MAP_N(MAP_N), .VECT_N(VECT_N),
        .FULL_N(FULL_N), .CNT_Z(CNT_Z), .ERR(ERR)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " CNT_Z"},  32'(CNT_Z),  32'(m_cnt == 0));
        check({tag, " FULL_N"}, 32'(FULL_N), 32'(m_depth != DEPTH));
        check({tag, " ERR"},    32'(ERR),    32'(m_err));
    endtask

    // Asynchronous reset, raised between edges; checked before any clock edge occurs.
    task automatic do_reset();
        @(negedge CP);
        I = 4'd5; CC_N = 1'b0; CCEN_N = 1'b0; D = '0;
        RST = 1'b1;
        m_cnt = 0; m_depth = 0; m_err = 1'b0;
        #1;
        check("rst S",      32'(S),      32'd0);
        check("rst FE",     32'(FE),     32'd1);
        check("rst PUP",    32'(PUP),    32'd0);
        check("rst RE",     32'(RE),     32'd1);
        check("rst ZERO",   32'(ZERO),   32'd0);
        check("rst PL_N",   32'(PL_N),   32'd0);
        check("rst MAP_N",  32'(MAP_N),  32'd1);
        check("rst VECT_N", 32'(VECT_N), 32'd1);
        check_state("rst");
        vectors++;
        @(negedge CP);
        I = 4'd14;
        RST = 1'b0;
    endtask

    task automatic step(input int op, input bit ccn, input bit ccen, input int dval);
        bit [1:0] es;
        bit ere, ezero, epl, emap, evect, push, pop, clr, pass;
        int dtr, ncnt;
        string tag;
        @(negedge CP);
        I = 4'(op); CC_N = ccn; CCEN_N = ccen; D = WIDTH'(dval);
        dtr = dval & ((1 << WIDTH) - 1);
        pass = ccen || !ccn;
        es = 2'd0; ere = 1; ezero = 1; epl = 0; emap = 1; evect = 1;
        push = 0; pop = 0; clr = 0; ncnt = m_cnt;
        case (op)
            0:  begin ezero = 0; clr = 1; end
            1:  if (pass) begin es = 3; push = 1; end
            2:  begin es = 3; emap = 0; epl = 1; end
            3:  if (pass) es = 3;
            4:  begin push = 1; if (pass) begin ncnt = dtr; ere = 0; end end
            5:  begin es = pass ? 2'd3 : 2'd1; push = 1; end
            6:  begin evect = 0; epl = 1; if (pass) es = 3; end
            7:  es = pass ? 2'd3 : 2'd1;
            8:  if (m_cnt > 0) begin es = 2; ncnt = m_cnt - 1; end else pop = 1;
            9:  if (m_cnt > 0) begin es = 3; ncnt = m_cnt - 1; end
            10: if (pass) begin es = 2; pop = 1; end
            11: if (pass) begin es = 3; pop = 1; end
            12: begin ncnt = dtr; ere = 0; end
            13: if (pass) pop = 1; else es = 2;
            15: if (pass) pop = 1;
                else if (m_cnt > 0) begin es = 2; ncnt = m_cnt - 1; end
                else begin es = 3; pop = 1; end
            default: ;
        endcase
        #1;
        tag = $sformatf("op%0d pass%0d", op, pass);
        check({tag, " S"},      32'(S),      32'(es));
        check({tag, " FE"},     32'(FE),     32'(!(push || pop)));
        check({tag, " PUP"},    32'(PUP),    32'(push));
        check({tag, " RE"},     32'(RE),     32'(ere));
        check({tag, " ZERO"},   32'(ZERO),   32'(ezero));
        check({tag, " PL_N"},   32'(PL_N),   32'(epl));
        check({tag, " MAP_N"},  32'(MAP_N),  32'(emap));
        check({tag, " VECT_N"}, 32'(VECT_N), 32'(evect));
        check_state(tag);
        vectors++;
        @(posedge CP);
`ifdef AM2909_CTRL_STACK_ERR_EN
        if ((push && m_depth == DEPTH) || (pop && m_depth == 0)) m_err = 1'b1;
`endif
        m_cnt = ncnt;
        if (clr)       m_depth = 0;
        else if (push) m_depth = (m_depth < DEPTH) ? m_depth + 1 : DEPTH;
        else if (pop)  m_depth = (m_depth > 0) ? m_depth - 1 : 0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_cnt = 0; m_depth = 0; m_err = 1'b0;
        RST = 1'b0; I = 4'd14; CC_N = 1'b1; CCEN_N = 1'b1; D = '0;

        do_reset();
        step(14, 1, 1, 0);
        // Load 3 then count down through RFCT to the final pop
        step(12, 1, 1, 3);
        for (int k = 0; k < 4; k++) step(8, 1, 1, 0);
        step(14, 1, 1, 0);
        // Fill the stack via CJS, then a failing CJS, then an overflowing push
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(14, 1, 1, 0);
        // TWB failing with counter zero, then with counter two
        step(15, 1, 0, 0);
        step(12, 1, 1, 2);
        step(15, 1, 0, 0);
        step(14, 1, 1, 0);
        // JZ clears depth; an extra pop underflows
        step(0, 1, 1, 0);
        step(10, 0, 0, 0);
        step(14, 1, 1, 0);
        // Max-width load and RPCT, JMAP, CJV, JRP, JSRP, LOOP
        step(4, 0, 0, 4095);
        step(9, 1, 1, 0);
        step(2, 1, 1, 0);
        step(6, 1, 0, 0);
        step(7, 1, 0, 0);
        step(5, 1, 0, 0);
        step(13, 1, 0, 0);
        step(13, 0, 0, 0);
        // Asynchronous reset while the stack is full and the counter loaded
        for (int k = 0; k < 4; k++) step(4, 0, 0, 7);
        do_reset();
        step(14, 1, 1, 0);

        for (int n = 0; n < 400; n++) begin
            int op, dv;
            op = int'($urandom_range(0, 15));
            dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 4));
            if ($urandom_range(0, 60) == 0) do_reset();
            else step(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
